// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM/WB writeback queue with valid/ready handshake; optional zero-latency path under MEM_WB_BYPASS_EN
module mem_wb_pipe #(
  parameter int DATA_W = 8,
  parameter int DST_W  = 2,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_reg_write,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DST_W-1:0]  mem_reg_dist,
  input  logic [SEL_W-1:0]  wb_result_mux_mem,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_result,
  output logic [DST_W-1:0]  wb_reg_dist,
  output logic [SEL_W-1:0]  wb_result_mux,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 1 + DATA_W + DST_W + SEL_W;
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [ENT_W-1:0] ent_q [DEPTH];
  logic [ENT_W-1:0] ent_d [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;

  logic             push, pop, store, bypass;
  logic [ENT_W-1:0] mem_ent, out_ent;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign mem_ent   = {mem_reg_write, mem_result, mem_reg_dist, wb_result_mux_mem};
  // Ready depends on occupancy alone so MEM never sees a path from wb_ready.
  assign mem_ready = (cnt_q < DEPTH_C);
  assign push      = mem_valid & mem_ready;
  assign pop       = (cnt_q != '0) & wb_ready;
  assign occupancy = cnt_q;

`ifdef MEM_WB_BYPASS_EN
  assign bypass = (cnt_q == '0) & mem_valid & wb_ready & ~flush & rst;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is handed straight to WB and never occupies a slot.
  assign store = push & ~bypass;

  // Next-state for pointers, count and storage; flush drops everything in flight.
  always_comb begin
    ent_d = ent_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (store) begin
        ent_d[wp_q] = mem_ent;
        wp_d        = ptr_inc(wp_q);
      end
      if (pop) begin
        rp_d = ptr_inc(rp_q);
      end
      if (store && !pop) begin
        cnt_d = cnt_q + OCC_W'(1);
      end else if (pop && !store) begin
        cnt_d = cnt_q - OCC_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset clearing every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Head presentation: stored head, or the MEM entry when bypassing; zeros when empty.
  always_comb begin
    wb_valid = (cnt_q != '0);
    out_ent  = ent_q[rp_q];
    if (bypass) begin
      wb_valid = 1'b1;
      out_ent  = mem_ent;
    end
    if (!wb_valid) begin
      out_ent = '0;
    end
  end

  assign {wb_reg_write, wb_result, wb_reg_dist, wb_result_mux} = out_ent;

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB stage buffer; successor to the single-register MEM/WB latch.
- Holds DEPTH in-flight writeback entries {reg_write, result, reg_dist, result_mux} in a circular queue.
- Valid/ready handshake on both sides: MEM can stall on back-pressure and WB can stall without losing entries.
- Flush drops every held entry; occupancy is exported for hazard/stall logic.

Parameters:
- DATA_W, 8, width of result.
- DST_W, 2, width of destination register index.
- SEL_W, 3, width of writeback result-mux select.
- DEPTH, 2, number of entries; legal range 1..16; need not be a power of two.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (state cleared on a clk rising edge while rst==0).
- flush  input  1  synchronous clear of all held entries.
- mem_valid  input  1  MEM offers an entry this cycle.
- mem_ready  output  1  buffer accepts the offered entry this cycle.
- mem_reg_write  input  1  entry writes the register file.
- mem_result  input  DATA_W  result value.
- mem_reg_dist  input  DST_W  destination register index.
- wb_result_mux_mem  input  SEL_W  writeback mux select.
- wb_valid  output  1  head entry present.
- wb_ready  input  1  WB consumes the head entry this cycle.
- wb_reg_write  output  1  head reg_write AND wb_valid.
- wb_result  output  DATA_W  head result.
- wb_reg_dist  output  DST_W  head destination.
- wb_result_mux  output  SEL_W  head mux select.
- occupancy  output  clog2(DEPTH+1)  number of held entries.

Behaviour:
- Storage: DEPTH-entry array, write pointer wp, read pointer rp, counter cnt. Pointers wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
- push = mem_valid & mem_ready.
- pop = wb_valid & wb_ready.
- mem_ready = (cnt < DEPTH), combinational from cnt only, never from wb_ready. At full, mem_ready=0 even if a pop happens the same cycle.
- wb_valid = (cnt != 0).
- Head outputs are registered storage reads; no combinational path from mem_* to wb_* (feature off).
- When wb_valid=0: wb_reg_write=0, wb_result=0, wb_reg_dist=0, wb_result_mux=0.
- Latency: an entry pushed at edge N is visible on wb_* after edge N (one cycle minimum).
- Push only: store at wp, wp+1, cnt+1.
- Pop only: rp+1, cnt-1.
- Push and pop together: both pointers advance, cnt unchanged. Ordering is strict FIFO.
- Entries with mem_reg_write=0 are stored and popped like any other; they are not squashed.
- mem_valid=1 while mem_ready=0: nothing stored. MEM must hold its inputs stable until accepted.
- wb_ready while wb_valid=0: ignored.
- flush=1: next cycle cnt=0, wp=rp=0. Any simultaneous push or pop is discarded. flush outranks everything except reset.
- Reset (rst==0 at an edge): cnt=0, wp=rp=0, every stored entry cleared to 0, every output at its empty value, mem_ready=1 the cycle after.
- Reset during a full, stalled state behaves identically; no entry survives.
- occupancy = cnt; reset value 0.

Optional Feature:
- Macro: MEM_WB_BYPASS_EN.
- Defined: when cnt==0, mem_valid=1 and wb_ready=1 (no flush, rst==1), the MEM entry appears combinationally on wb_* with wb_valid=1 and is consumed without being stored. Result: zero-latency passthrough, cnt stays 0. mem_ready is still derived from cnt only. flush=1 suppresses the bypass: wb_valid=0 that cycle.
- Undefined: no combinational mem_*->wb_* path; minimum latency is one cycle as above.

Test Plan:
- Reset/empty: hold rst=0 for 2 edges with mem_valid=1, then release -> occupancy=0, wb_valid=0, all wb_* = 0, mem_ready=1.
- Streaming (DEPTH=2, wb_ready=1): push results 0x11,0x22,0x33 on consecutive cycles, dist 1,2,3, reg_write=1 -> wb_result 0x11,0x22,0x33 one cycle later each, in order; occupancy never exceeds 1.
- Back-pressure: wb_ready=0, push 0xA1,0xA2,0xA3 -> after two pushes mem_ready=0, occupancy=2, 0xA3 held at input. Raise wb_ready -> outputs 0xA1, 0xA2, then 0xA3; nothing lost or duplicated.
- Flush race: at occupancy=2, assert flush together with mem_valid=1 (0x55) and wb_ready=1 -> next cycle occupancy=0, wb_valid=0, 0x55 never appears on wb_result.
- Wrap (DEPTH=3): 10 push/pop pairs with a random stall pattern, results 0..9 -> output sequence exactly 0..9; occupancy matches a reference count every cycle.
- Bubble: push reg_write=0 with result 0xFF -> wb_valid=1, wb_reg_write=0, wb_result=0xFF. Under MEM_WB_BYPASS_EN, with the buffer empty and wb_ready=1, push 0x3C -> wb_result=0x3C in the same cycle, occupancy stays 0.
